fireball_motion_detector: RTL

//  Decodes a quarter-circle-forward + punch motion (down, down+fwd, fwd, punch) from one player's

---
 rtl/fireball_motion_detector_pkg.sv | 25 ++
 rtl/fireball_motion_detector_if.sv | 27 ++
 rtl/fireball_motion_detector_step_timer.sv | 29 ++
 rtl/fireball_motion_detector.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/fireball_motion_detector_pkg.sv
// Shared encodings for the fireball motion decoder: projectile states,
// facing directions, motion FSM states and a saturating subtract helper.
package fireball_motion_detector_pkg;

    localparam logic [1:0] FIREBALL_DISABLED  = 2'd0;
    localparam logic [1:0] FIREBALL_ENABLED   = 2'd1;
    localparam logic [1:0] FIREBALL_EXPLOSION = 2'd2;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    typedef enum logic [2:0] {
        MOTION_IDLE     = 3'd0,
        MOTION_GOT_DOWN = 3'd1,
        MOTION_GOT_DIAG = 3'd2,
        MOTION_GOT_FWD  = 3'd3,
        MOTION_LAUNCH   = 3'd4
    } motion_state_e;

    // a - b, clamped at zero instead of wrapping.
    function automatic logic [9:0] sat_sub10(input logic [9:0] a, input logic [9:0] b);
        return (a > b) ? (a - b) : 10'd0;
    endfunction

endpackage

// File: rtl/fireball_motion_detector_if.sv
// Launch bus between the motion decoder (master) and the fireball
// projectile block (slave), including the projectile's state feedback.
interface fireball_motion_detector_if;

    logic       fb_enabled;
    logic       fb_direction;
    logic [9:0] fb_start_x;
    logic [9:0] fb_start_y;
    logic [1:0] fireball_state;

    modport master (
        output fb_enabled,
        output fb_direction,
        output fb_start_x,
        output fb_start_y,
        input  fireball_state
    );

    modport slave (
        input  fb_enabled,
        input  fb_direction,
        input  fb_start_x,
        input  fb_start_y,
        output fireball_state
    );

endinterface

// File: rtl/fireball_motion_detector_step_timer.sv
// Step timer for special-move decoders: counts cycles spent waiting on the
// next motion step and flags the last allowed cycle (count == STEP_WINDOW-1).
module fireball_motion_detector_step_timer #(
    parameter int STEP_WINDOW = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = $clog2(STEP_WINDOW);

    logic [W-1:0] count_q;

    // Counter: clear has priority, otherwise count while enabled.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expire = (count_q == W'(STEP_WINDOW - 1));

endmodule

// File: rtl/fireball_motion_detector.sv
// Quarter-circle-forward + punch decoder that launches one player's
// fireball. Optional feature macro: FIREBALL_COOLDOWN_EN adds a post-launch
// lockout counter; without it launches are gated by fireball_state only.
module fireball_motion_detector
    import fireball_motion_detector_pkg::*;
#(
    parameter int STEP_WINDOW = 8,
    parameter int FIRE_HOLD   = 2,
    parameter int Y_OFFSET    = 16
`ifdef FIREBALL_COOLDOWN_EN
    ,
    parameter int COOLDOWN    = 64
`endif
) (
    input  logic                       clk,
    input  logic                       start,
    input  logic                       facing,
    input  logic [9:0]                 player_x,
    input  logic [9:0]                 player_y,
    input  logic                       joy_down,
    input  logic                       joy_left,
    input  logic                       joy_right,
    input  logic                       punch,
    fireball_motion_detector_if.master fb,
    output logic [2:0]                 motion_state
);

    localparam int HOLD_W = (FIRE_HOLD > 1) ? $clog2(FIRE_HOLD) : 1;

    motion_state_e     state_q, state_next;
    logic              dir_q;
    logic              punch_q;
    logic [HOLD_W-1:0] hold_q;

    logic dir_sel, lr_valid, fwd, back, punch_rise;
    logic in_step, step_expire, hold_done, launch_entry, launch_ok;

    // Before the sequence starts, use live facing; afterwards the latched one.
    assign dir_sel    = (state_q == MOTION_IDLE) ? facing : dir_q;
    // Left and right together cancel out: neither forward nor back.
    assign lr_valid   = joy_left ^ joy_right;
    assign fwd        = lr_valid & ((dir_sel == RIGHT) ? joy_right : joy_left);
    assign back       = lr_valid & ((dir_sel == LEFT)  ? joy_right : joy_left);
    assign punch_rise = punch & ~punch_q;

    assign in_step      = (state_q == MOTION_GOT_DOWN) || (state_q == MOTION_GOT_DIAG) ||
                          (state_q == MOTION_GOT_FWD);
    assign hold_done    = (hold_q == HOLD_W'(FIRE_HOLD - 1));
    assign launch_entry = (state_next == MOTION_LAUNCH) && (state_q != MOTION_LAUNCH);

`ifdef FIREBALL_COOLDOWN_EN
    logic [6:0] cooldown_q;

    // Lockout counter: reload on each launch, then run down to zero.
    always_ff @(posedge clk) begin
        if (start) begin
            cooldown_q <= '0;
        end else if (launch_entry) begin
            cooldown_q <= 7'(COOLDOWN);
        end else if (cooldown_q != '0) begin
            cooldown_q <= cooldown_q - 1'b1;
        end
    end

    assign launch_ok = (fb.fireball_state == FIREBALL_DISABLED) && (cooldown_q == '0);
`else
    assign launch_ok = (fb.fireball_state == FIREBALL_DISABLED);
`endif

    fireball_motion_detector_step_timer #(
        .STEP_WINDOW (STEP_WINDOW)
    ) u_step_timer (
        .clk    (clk),
        .rst    (start),
        .clear  ((state_next != state_q) || !in_step),
        .enable (in_step),
        .expire (step_expire)
    );

    // Next-state logic: back abort beats advance, advance beats timeout.
    // NOTE: state_next gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state_q;
        case (state_q)
            MOTION_IDLE: begin
                if (joy_down && !fwd && !back) state_next = MOTION_GOT_DOWN;
            end
            MOTION_GOT_DOWN: begin
                if (back)                  state_next = MOTION_IDLE;
                else if (joy_down && fwd)  state_next = MOTION_GOT_DIAG;
                else if (step_expire)      state_next = MOTION_IDLE;
            end
            MOTION_GOT_DIAG: begin
                if (back)                  state_next = MOTION_IDLE;
                else if (fwd && !joy_down) state_next = MOTION_GOT_FWD;
                else if (step_expire)      state_next = MOTION_IDLE;
            end
            MOTION_GOT_FWD: begin
                if (back)                  state_next = MOTION_IDLE;
                else if (punch_rise)       state_next = launch_ok ? MOTION_LAUNCH : MOTION_IDLE;
                else if (step_expire)      state_next = MOTION_IDLE;
            end
            MOTION_LAUNCH: begin
                if (hold_done)             state_next = MOTION_IDLE;
            end
            default:                       state_next = MOTION_IDLE;
        endcase
    end

    // State, direction/punch history, hold counter and latched launch outputs.
    always_ff @(posedge clk) begin
        if (start) begin
            state_q         <= MOTION_IDLE;
            dir_q           <= 1'b0;
            punch_q         <= 1'b0;
            hold_q          <= '0;
            fb.fb_enabled   <= 1'b0;
            fb.fb_direction <= 1'b0;
            fb.fb_start_x   <= '0;
            fb.fb_start_y   <= '0;
        end else begin
            state_q       <= state_next;
            punch_q       <= punch;
            fb.fb_enabled <= (state_next == MOTION_LAUNCH);
            if (state_q == MOTION_IDLE && state_next == MOTION_GOT_DOWN) begin
                dir_q <= facing;
            end
            if (launch_entry) begin
                hold_q          <= '0;
                fb.fb_direction <= dir_q;
                fb.fb_start_x   <= player_x;
                fb.fb_start_y   <= sat_sub10(player_y, 10'(Y_OFFSET));
            end else if (state_q == MOTION_LAUNCH) begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end

    assign motion_state = state_q;

endmodule
